ram8_scrub: RTL and testbench

- 8-word x 16-bit register memory. Sits directly downstream of the 16-bit gate stage (And16/Mux16 outputs), capturing its 16-bit results.
- This is the first clocked storage element after the combinational gate library. It is addressed like the classic RAM8: `load` writes `in` at `address`, and `out` reads at `address`.
- Adds a sequential scrub engine that zeroes all words one per cycle on request, with busy/done handshake.

---
 rtl/ram8_scrub.sv | 141 ++++++++++++++
 tb/tb_ram8_scrub.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram8_scrub.sv
// ram8_scrub: 8-word x 16-bit register memory with a sequential scrub engine.
//
// The first clocked storage after the 16-bit gate stage. Addressed like the
// classic RAM8: `load` writes `in` at `address`, `out` reads `address`.
// A `clear` request starts a scrub that zeroes one word per cycle, lowest
// address first, while `busy` is high; `done` pulses for one cycle afterwards.
//
// Ports:
//   clk      in   single clock, all state changes on the rising edge
//   reset    in   synchronous, active-high; clears memory, FSM and flags
//   in       in   [WIDTH-1:0] write data
//   load     in   write enable for mem[address] (honoured only when idle)
//   address  in   [ADDR_W-1:0] read/write word address
//   clear    in   scrub request (honoured only when idle, wins over load)
//   out      out  [WIDTH-1:0] read data for mem[address]
//   busy     out  high while the scrub is in progress (the FSM state)
//   done     out  one-cycle pulse on the first idle cycle after a scrub
//
// Handshake: a scrub is requested by clear=1 at an edge while busy=0; busy
// rises on that edge and stays high for exactly 2**ADDR_W cycles, during which
// clear and load are ignored; done is high for the single cycle that follows.
//
// Optional build macro RAM8_SCRUB_REGOUT_EN: registers `out` (1-cycle read
// latency, write-first on same-address writes, including scrub zeroing).
// Without it `out` is a combinational read of mem[address].

module ram8_scrub #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  ptr, ptr_next;
  logic               done_q, done_next;

  logic [WIDTH-1:0]   mem [DEPTH];

  // Single write port shared by host writes and scrub zeroing.
  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic [WIDTH-1:0]   wdata;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      done_q <= done_next;
    end
  end

  // Next state, pointer, done pulse and write-port selection
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    done_next  = 1'b0;
    we         = 1'b0;
    waddr      = address;
    wdata      = in;
    unique case (state)
      IDLE: begin
        if (clear) begin
          // A scrub request swallows any load presented in the same cycle.
          state_next = SCRUB;
          ptr_next   = '0;
        end else if (load) begin
          we = 1'b1;
        end
      end
      SCRUB: begin
        we       = 1'b1;
        waddr    = ptr;
        wdata    = '0;
        ptr_next = ptr + ONE;
        if (ptr == LAST_ADDR) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign busy = (state == SCRUB);
  assign done = done_q;

`ifdef RAM8_SCRUB_REGOUT_EN
  // Registered read, write-first: a write (or scrub zero) landing on the
  // word being read this edge is forwarded instead of the stale array value.
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (we && (waddr == address)) begin
      out_q <= wdata;
    end else begin
      out_q <= mem[address];
    end
  end

  assign out = out_q;
`else
  assign out = mem[address];
`endif

endmodule

// File: tb/tb_ram8_scrub.sv
// Self-checking bench for ram8_scrub: directed vector table, hand-written
// scrub/reset sequences and randomized traffic checked against a word-array
// reference model that counts remaining scrub words.

module tb_ram8_scrub;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  din;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic              clear;
  logic [WIDTH-1:0]  dout;
  logic              busy;
  logic              done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ram8_scrub #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (dout),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] model_mem [DEPTH];
  int               scrub_left;   // words still to be zeroed by the scrub
  logic             model_done;

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      scrub_left = 0;
      model_done = 1'b0;
    end else if (scrub_left > 0) begin
      model_mem[DEPTH - scrub_left] = '0;
      scrub_left--;
      model_done = (scrub_left == 0);
    end else begin
      model_done = 1'b0;
      if (clear) scrub_left = DEPTH;
      else if (load) model_mem[address] = din;
    end
  endtask

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    exp_q.push_back(model_mem[address]);
    check({name, ".out"}, 32'(dout), 32'(exp_q.pop_front()));
    check({name, ".busy"}, 32'(busy), 32'(scrub_left != 0));
    check({name, ".done"}, 32'(done), 32'(model_done));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic ld, input logic cl,
                       input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    reset   = r;
    load    = ld;
    clear   = cl;
    address = a;
    din     = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              r;
    logic              ld;
    logic              cl;
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  d;
    logic [WIDTH-1:0]  exp_out;
    logic              exp_busy;
    logic              exp_done;
  } vec_t;

  vec_t vecs[$];

  int busy_cycles;

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    scrub_left = 0;
    model_done = 1'b0;

    // Expected values after the edge, with the vector's address still applied.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0});
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back('{1'b0, 1'b0, 1'b0, 3'(i), 16'h0000, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd3, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd7, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd3, 16'h1234, 16'hA5A5, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd7, 16'h1234, 16'hFFFF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].ld, vecs[i].cl, vecs[i].a, vecs[i].d);
      tick();
      check($sformatf("vec%0d.out", i), 32'(dout), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].exp_done));
    end

`ifndef RAM8_SCRUB_REGOUT_EN
    // Combinational read: old value before the write edge, new value after.
    drive(1'b0, 1'b1, 1'b0, 3'd5, 16'h3C3C);
    #1;
    check("pre_write_addr5", 32'(dout), 32'h0000);
    tick();
    check("post_write_addr5", 32'(dout), 32'h3C3C);
`else
    // Registered read: write-first, and address changes show after one edge.
    drive(1'b0, 1'b1, 1'b0, 3'd4, 16'h5A5A);
    tick();
    check("regout_write_first", 32'(dout), 32'h5A5A);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    #1;
    check("regout_stale_before_edge", 32'(dout), 32'h5A5A);
    tick();
    check("regout_addr0_after_edge", 32'(dout), 32'h0000);
`endif

    // ---- fill then scrub, watch busy length, done pulse, partial reads ----
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(i), 16'(16'h1111 * (i + 1)));
      tick();
      check_model("fill");
    end
    drive(1'b0, 1'b0, 1'b1, 3'd5, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd5, 16'h0000);
    busy_cycles = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      busy_cycles++;
      if (busy_cycles == 4) check("scrub_cycle4_addr5", 32'(dout), 32'h6666);
      check_model("scrub1");
      tick();
    end
    check("scrub1_busy_cycles", 32'(busy_cycles), 32'd8);
    check("scrub1_done_pulse", 32'(done), 32'd1);
    check_model("scrub1_end");
    tick();
    check("scrub1_done_drop", 32'(done), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b0, 3'(i), 16'h0000);
      tick();
      check($sformatf("scrubbed_word%0d", i), 32'(dout), 32'h0000);
    end

    // ---- clear beats load; load and clear ignored while busy ----
    drive(1'b0, 1'b1, 1'b1, 3'd2, 16'hBEEF);
    tick();
    check("clear_beats_load_busy", 32'(busy), 32'd1);
    busy_cycles = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      busy_cycles++;
      if (busy_cycles >= 5) drive(1'b0, 1'b1, 1'b1, 3'd0, 16'h1234);
      else drive(1'b0, 1'b0, 1'b0, 3'd2, 16'h0000);
      check_model("scrub2");
      tick();
    end
    check("scrub2_busy_cycles", 32'(busy_cycles), 32'd8);
    check("scrub2_done_pulse", 32'(done), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    tick();
    check("busy_load_ignored_addr0", 32'(dout), 32'h0000);
    check("scrub2_no_restart", 32'(busy), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 3'd2, 16'h0000);
    tick();
    check("clear_load_addr2", 32'(dout), 32'h0000);

    // ---- clear held high re-triggers on the done cycle ----
    drive(1'b0, 1'b0, 1'b1, 3'd1, 16'h0000);
    tick();
    for (int k = 0; k < 8; k++) begin
      check_model("hold_clear");
      tick();
    end
    check("hold_clear_done", 32'(done), 32'd1);
    check("hold_clear_idle", 32'(busy), 32'd0);
    tick();
    check("hold_clear_retrigger", 32'(busy), 32'd1);
    check("hold_clear_done_low", 32'(done), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 3'd1, 16'h0000);
    for (int k = 0; k < 20 && (busy || done); k++) begin
      check_model("hold_clear_drain");
      tick();
    end
    check_model("hold_clear_quiet");

    // ---- reset during the 3rd busy cycle aborts the scrub ----
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(i), 16'hCAFE);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 3'd6, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd6, 16'h0000);
    tick();
    tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 3'd6, 16'h0000);
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_word6", 32'(dout), 32'h0000);
    drive(1'b0, 1'b0, 1'b0, 3'd6, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b0, 3'(i), 16'h0000);
      tick();
      check($sformatf("abort_word%0d", i), 32'(dout), 32'h0000);
    end
    drive(1'b0, 1'b1, 1'b0, 3'd0, 16'h0042);
    tick();
    check("post_abort_write", 32'(dout), 32'h0042);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 24) == 0),
            3'($urandom_range(0, DEPTH - 1)),
            16'($urandom));
`ifndef RAM8_SCRUB_REGOUT_EN
      #1;
      check("rand_comb_read", 32'(dout), 32'(model_mem[address]));
`endif
      tick();
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
